axis_insert_header_pipe: RTL and testbench
==========================================

# axis_insert_header_pipe

Parametrised, fully registered header-insertion stage for AXI-Stream packets. It accepts one header of 1..DATA_BYTE_WD bytes per packet and prepends it to the packet, packing bytes MSB-first with no gaps. It emits the trailing residual beat when the packed length spills over. It sits between a packet source and the downstream AXI-Stream sink and is the production successor of the single-cycle header inserter.

## Interface
- DATA_WD, 32, data bus width in bits; must be a multiple of 8, at least 16.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (N).
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt.

Clocking and reset (already decided): one clock; reset is synchronous and active-high.

- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-high reset; the port name is kept for codebase consistency.
- valid_in / ready_in  in / out  1  input beat handshake.
- data_in  in  DATA_WD  input data; byte N-1 (MSBs) is first on the wire.
- keep_in  in  DATA_BYTE_WD  byte enables; honoured only on the last beat, where they are MSB-contiguous.
- last_in  in  1  last beat of the input packet.
- valid_out / ready_out  out / in  1  output beat handshake.
- data_out  out  DATA_WD  packed output data.
- keep_out  out  DATA_BYTE_WD  all ones except on the last beat, which is MSB-contiguous.
- last_out  out  1  last beat of the output packet.
- valid_insert / ready_insert  in / out  1  header handshake.
- data_insert  in  DATA_WD  header; the H least-significant bytes are valid.
- keep_insert  in  DATA_BYTE_WD  informational only; byte_insert_cnt governs.
- byte_insert_cnt  in  BYTE_CNT_WD  header length H = byte_insert_cnt+1.

## Operation
- **Residual register** R holds r bytes, 0..N.
  - On header handshake: R gets the H header bytes, left-justified; r=H.
  - Input beat carrying k bytes: k=N on non-last beats; on the last beat, k = popcount(keep_in).
  - The combined stream is R followed by the input bytes.
  - If r+k >= N: emit the first N bytes, keep r+k-N bytes in R.
  - If r+k < N: R absorbs all bytes (this case only occurs on the last beat).
- **States:**
  - IDLE: ready_insert=1, ready_in=0. Header handshake -> STREAM.
  - STREAM: ready_in = !valid_out || ready_out. A non-last beat always emits one full beat.
  - Last beat with r+k <= N: emit r+k bytes with last_out=1; keep_out has the top r+k bits set. Go to IDLE, r=0.
  - Last beat with r+k > N: emit N bytes with last_out=0, then go to TAIL with r+k-N bytes.
  - TAIL: ready_in=0. When the output slot is free, emit R with last_out=1, then go to IDLE.
- Output beat count per packet = ceil((H+L)/N), where L is the payload byte count.
- Unused low data_out bytes are driven to 0.
- Degenerate last beat (last_in with keep_in=0) is treated as k=0.
- keep_in on non-last beats is treated as all ones.

## Timing
- **Reset:** while rst_n=1, and on the cycle after it is released:
  - valid_out=0, data_out=0, keep_out=0, last_out=0;
  - ready_in=0, ready_insert=0 while in reset; state=IDLE, r=0.
- After reset: ready_insert=1 on the first cycle with rst_n=0.
- **Latency:**
  - Header handshake at cycle t -> ready_in may be 1 at t+1.
  - Input handshake at t -> the corresponding valid_out at t+1.
- **Output register:** holds data, keep and last stable while valid_out && !ready_out.
  - It is loaded only when !valid_out || ready_out.
- **Throughput:** one beat/cycle inside a packet.
  - Minimum one idle-input cycle between packets (IDLE header cycle), plus one more when TAIL is used.
- Reset asserted mid-packet: the packet is abandoned, no partial last_out is produced, and all state clears next edge.
- valid_insert held during STREAM/TAIL: not accepted, and the header is not consumed.

## Configuration
- **AXIS_INSERT_HDR_STATS_EN defined:** adds two outputs, both cleared by reset and wrapping modulo 2^32.
  - pkt_cnt (out, 32): increments on each last_out handshake.
  - beat_cnt (out, 32): increments on each valid_out && ready_out.
- **Undefined:** these ports and counters are absent; behaviour is otherwise identical.

## Test plan
- **Two-byte header, spill into tail beat:** DATA_WD=32, cnt=1, data_insert=0x0000AABB; beats 0x11223344, then 0x55667788 with last, keep 1111.
  - Required output: 0xAABB1122/1111, 0x33445566/1111, 0x77880000/1100 with last.
- **Full-width header:** cnt=3, 0xDEADBEEF; one beat 0x01020304, keep 1110, last.
  - Required output: 0xDEADBEEF/1111, then 0x01020300/1110 with last, through TAIL.
- **Exact fit, no tail:** cnt=0, 0x000000CC; one beat 0xA1A2A300, keep 1110, last.
  - Required output: a single beat 0xCCA1A2A3/1111 with last; TAIL is never entered.
- **Backpressure:** ready_out held at 0 for 3 cycles mid-packet.
  - Required: data/keep/last stable, ready_in=0, no beat lost or duplicated, full throughput resumes.
- **Reset mid-packet:** rst_n=1 for one cycle after the second beat.
  - Required: all outputs at reset values, ready_insert=1 next cycle, and the following packet is correct.
- **Stats (macro on):** 3 packets of scenario 1.
  - Required: pkt_cnt=3, beat_cnt=9.

Source files
------------

// File: rtl/axis_insert_header_pipe.sv
// rtl/axis_insert_header_pipe.sv - registered AXI-Stream header inserter with residual byte packing
// Optional statistics counters enabled by defining AXIS_INSERT_HDR_STATS_EN.
module axis_insert_header_pipe #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    valid_insert,
  output logic                    ready_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt
`ifdef AXIS_INSERT_HDR_STATS_EN
  ,
  output logic [31:0]             pkt_cnt,
  output logic [31:0]             beat_cnt
`endif
);

  localparam int N  = DATA_BYTE_WD;
  localparam int RW = BYTE_CNT_WD + 1;
  localparam int SW = BYTE_CNT_WD + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_TAIL
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [RW-1:0]           rcnt_q, rcnt_d;
  logic                    vout_q, vout_d;
  logic [DATA_WD-1:0]      dout_q, dout_d;
  logic [N-1:0]            kout_q, kout_d;
  logic                    lout_q, lout_d;

  logic                    out_free;
  logic                    in_hs;
  logic                    ins_hs;
  logic [RW-1:0]           kcnt;
  logic [DATA_WD-1:0]      data_m;
  logic [2*DATA_WD-1:0]    combined;
  logic [SW-1:0]           total;
  logic [DATA_WD-1:0]      hdr_aligned;
  logic                    unused_keep_insert;

  function automatic logic [N-1:0] keep_top(input logic [SW-1:0] m);
    keep_top = '0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) < m) keep_top[N-1-i] = 1'b1;
    end
  endfunction

  assign unused_keep_insert = ^keep_insert;

  assign out_free     = !vout_q || ready_out;
  assign ready_in     = !rst_n && (state_q == S_STREAM) && out_free;
  assign ready_insert = !rst_n && (state_q == S_IDLE);
  assign in_hs        = valid_in && ready_in;
  assign ins_hs       = valid_insert && ready_insert;

  // Only the last beat is sparse; unkept bytes are zeroed so they never leak into data_out.
  always_comb begin
    kcnt   = '0;
    data_m = '0;
    for (int i = 0; i < N; i++) begin
      if (!last_in || keep_in[i]) begin
        data_m[i*8 +: 8] = data_in[i*8 +: 8];
        kcnt             = kcnt + RW'(1);
      end
    end
  end

  // Residual bytes sit at the top of a 2N-byte window; the beat lands right after them.
  assign combined    = {res_q, {DATA_WD{1'b0}}} | ({data_m, {DATA_WD{1'b0}}} >> {rcnt_q, 3'b000});
  assign total       = SW'(rcnt_q) + SW'(kcnt);
  assign hdr_aligned = data_insert << {BYTE_CNT_WD'(N - 1) - byte_insert_cnt, 3'b000};

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    rcnt_d  = rcnt_q;
    vout_d  = vout_q && !ready_out;
    dout_d  = dout_q;
    kout_d  = kout_q;
    lout_d  = lout_q;
    case (state_q)
      S_IDLE: begin
        if (ins_hs) begin
          res_d   = hdr_aligned;
          rcnt_d  = RW'(byte_insert_cnt) + RW'(1);
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (in_hs) begin
          vout_d = 1'b1;
          dout_d = combined[2*DATA_WD-1 -: DATA_WD];
          if (last_in && (total <= SW'(N))) begin
            kout_d  = keep_top(total);
            lout_d  = 1'b1;
            res_d   = '0;
            rcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            kout_d = '1;
            lout_d = 1'b0;
            res_d  = combined[DATA_WD-1:0];
            rcnt_d = RW'(total - SW'(N));
            if (last_in) state_d = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (out_free) begin
          vout_d  = 1'b1;
          dout_d  = res_q;
          kout_d  = keep_top(SW'(rcnt_q));
          lout_d  = 1'b1;
          res_d   = '0;
          rcnt_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      rcnt_q  <= '0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
      kout_q  <= '0;
      lout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
      kout_q  <= kout_d;
      lout_q  <= lout_d;
    end
  end

  assign valid_out = vout_q;
  assign data_out  = dout_q;
  assign keep_out  = kout_q;
  assign last_out  = lout_q;

`ifdef AXIS_INSERT_HDR_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else if (vout_q && ready_out) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
      if (lout_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_axis_insert_header_pipe.sv
// tb/tb_axis_insert_header_pipe.sv - scoreboard bench for axis_insert_header_pipe
// Honours AXIS_INSERT_HDR_STATS_EN when defined.
module tb_axis_insert_header_pipe;

  localparam int DW = 32;
  localparam int N  = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [N-1:0]  k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in, ready_in, last_in;
  logic [DW-1:0] data_in;
  logic [N-1:0]  keep_in;
  logic          valid_out, ready_out, last_out;
  logic [DW-1:0] data_out;
  logic [N-1:0]  keep_out;
  logic          valid_insert, ready_insert;
  logic [DW-1:0] data_insert;
  logic [N-1:0]  keep_insert;
  logic [1:0]    byte_insert_cnt;
`ifdef AXIS_INSERT_HDR_STATS_EN
  logic [31:0]   pkt_cnt, beat_cnt;
`endif

  axis_insert_header_pipe #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
    .keep_in(keep_in), .last_in(last_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .keep_out(keep_out), .last_out(last_out),
    .valid_insert(valid_insert), .ready_insert(ready_insert),
    .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt)
`ifdef AXIS_INSERT_HDR_STATS_EN
    , .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  beat_t       expq[$];
  byte unsigned pl[$];
  int          rdy_mode  = 0;
  int          stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no handshake, expected one at %0t", name, $time);
  endtask

  // Reference: flatten header+payload into a byte list and cut it into N-byte beats.
  task automatic push_model(input logic [DW-1:0] hdr, input int cnt);
    byte unsigned all[$];
    int nbo;
    beat_t e;
    for (int i = cnt; i >= 0; i--) all.push_back(hdr[i*8 +: 8]);
    foreach (pl[i]) all.push_back(pl[i]);
    nbo = (all.size() + N - 1) / N;
    for (int o = 0; o < nbo; o++) begin
      e = '0;
      for (int j = 0; j < N; j++) begin
        if (o*N + j < all.size()) begin
          e.d[(N-1-j)*8 +: 8] = all[o*N + j];
          e.k[N-1-j] = 1'b1;
        end
      end
      e.l = (o == nbo - 1);
      expq.push_back(e);
    end
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
    beat_t e;
    e.d = d; e.k = k; e.l = l;
    expq.push_back(e);
  endtask

  task automatic send_pkt(input logic [DW-1:0] hdr, input int cnt, input bit model,
                          input bit hold_ins, input int gap_max, input int stop_after,
                          input int stall_at, output int waits);
    int L, nb, m;
    bit ok;
    waits = 0;
    if (model) push_model(hdr, cnt);
    valid_insert = 1'b1;
    data_insert = hdr;
    byte_insert_cnt = cnt[1:0];
    keep_insert = N'($urandom);
    ok = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (ready_insert) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("header_handshake");
    @(posedge clk); #1;
    if (hold_ins) begin
      data_insert = $urandom;
      byte_insert_cnt = 2'($urandom);
    end else begin
      valid_insert = 1'b0;
    end
    L = pl.size();
    nb = (L == 0) ? 1 : (L + N - 1) / N;
    for (int b = 0; b < nb; b++) begin
      if (stop_after >= 0 && b >= stop_after) break;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      for (int j = 0; j < N; j++)
        data_in[(N-1-j)*8 +: 8] = (b*N + j < L) ? pl[b*N + j] : 8'($urandom);
      last_in = (b == nb - 1);
      if (last_in) begin
        m = L - b*N;
        keep_in = '0;
        for (int j = 0; j < m; j++) keep_in[N-1-j] = 1'b1;
      end else begin
        keep_in = N'($urandom);
      end
      valid_in = 1'b1;
      ok = 0;
      for (int t = 0; t < 500; t++) begin
        @(negedge clk);
        if (hold_ins) chk("ready_insert_busy", 64'(ready_insert), 64'd0);
        if (ready_in) begin ok = 1; break; end
        waits++;
      end
      if (!ok) timeout_fail("beat_handshake");
      @(posedge clk); #1;
      valid_in = 1'b0;
      last_in = 1'b0;
      if (b == stall_at) stall_cnt = 3;
    end
    valid_insert = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (expq.size() == 0) begin ok = 1; break; end
    end
    if (!ok) timeout_fail("drain");
    repeat (3) @(negedge clk);
  endtask

  task automatic load_scn1();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    push_beat(32'hAABB1122, 4'b1111, 1'b0);
    push_beat(32'h33445566, 4'b1111, 1'b0);
    push_beat(32'h77880000, 4'b1100, 1'b1);
  endtask

  task automatic rand_payload(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      if (stall_cnt > 0) begin
        ready_out = 1'b0;
        stall_cnt--;
      end else if (rdy_mode == 1) begin
        ready_out = ($urandom_range(0, 3) != 0);
      end else begin
        ready_out = 1'b1;
      end
    end
  end

  initial begin : monitor
    beat_t held, e;
    bit hold_pending = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        hold_pending = 0;
      end else begin
        if (hold_pending) begin
          chk("stall_valid", 64'(valid_out), 64'd1);
          chk("stall_data", 64'(data_out), 64'(held.d));
          chk("stall_keep_last", 64'({keep_out, last_out}), 64'({held.k, held.l}));
        end
        if (valid_out && ready_out) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h/%b last=%b, expected none", data_out, keep_out, last_out);
          end else begin
            e = expq.pop_front();
            chk("beat_data", 64'(data_out), 64'(e.d));
            chk("beat_keep", 64'(keep_out), 64'(e.k));
            chk("beat_last", 64'(last_out), 64'(e.l));
          end
        end
        if (valid_out && !ready_out) chk("stall_ready_in", 64'(ready_in), 64'd0);
        hold_pending = valid_out && !ready_out;
        held.d = data_out; held.k = keep_out; held.l = last_out;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    rst_n = 1'b1;
    valid_in = 0; last_in = 0; data_in = '0; keep_in = '0;
    valid_insert = 0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
    ready_out = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd0);
    chk("rst_ready_insert", 64'(ready_insert), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_insert", 64'(ready_insert), 64'd1);
    chk("post_rst_outputs", 64'({valid_out, data_out, keep_out, last_out}), 64'd0);
    @(posedge clk); #1;

    for (int p = 0; p < 3; p++) begin
      load_scn1();
      send_pkt(32'h0000AABB, 1, 0, 0, 0, -1, -1, w);
    end
    drain();
`ifdef AXIS_INSERT_HDR_STATS_EN
    chk("stats_pkt_cnt", 64'(pkt_cnt), 64'd3);
    chk("stats_beat_cnt", 64'(beat_cnt), 64'd9);
`endif
    @(posedge clk); #1;

    pl = '{8'h01, 8'h02, 8'h03};
    push_beat(32'hDEADBEEF, 4'b1111, 1'b0);
    push_beat(32'h01020300, 4'b1110, 1'b1);
    send_pkt(32'hDEADBEEF, 3, 0, 0, 0, -1, -1, w);

    pl = '{8'hA1, 8'hA2, 8'hA3};
    push_beat(32'hCCA1A2A3, 4'b1111, 1'b1);
    send_pkt(32'h000000CC, 0, 0, 0, 0, -1, -1, w);
    drain();
    @(posedge clk); #1;

    rand_payload(0);
    send_pkt($urandom, 2, 1, 0, 0, -1, -1, w);

    rand_payload(28);
    send_pkt($urandom, 1, 1, 0, 0, -1, -1, w);
    chk("throughput_waits", 64'(w), 64'd0);
    drain();
    @(posedge clk); #1;

    rand_payload(24);
    send_pkt($urandom, 2, 1, 1, 0, -1, 1, w);
    drain();
    @(posedge clk); #1;

    rand_payload(16);
    send_pkt($urandom, 2, 1, 0, 0, 2, -1, w);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    expq.delete();
    @(negedge clk);
    chk("midrst_outputs", 64'({valid_out, data_out, keep_out, last_out}), 64'd0);
    chk("midrst_ready_insert", 64'(ready_insert), 64'd1);
    chk("midrst_ready_in", 64'(ready_in), 64'd0);
    @(posedge clk); #1;
    load_scn1();
    send_pkt(32'h0000AABB, 1, 0, 0, 0, -1, -1, w);
    drain();
    @(posedge clk); #1;

    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      rand_payload($urandom_range(0, 13));
      send_pkt($urandom, $urandom_range(0, 3), 1, $urandom_range(0, 1), 2, -1, -1, w);
    end
    rdy_mode = 0;
    drain();
    chk("final_queue_empty", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
